// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign-corrected on the final iteration.
module mul_div_unit #(
  parameter int XLEN   = 32,
  parameter int CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(CYCLES);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand signedness from the RV32M encoding
  logic            a_sgn, b_sgn, in_neg_a, in_neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign in_neg_a = a_sgn & SrcA[XLEN-1];
  assign in_neg_b = b_sgn & SrcB[XLEN-1];
  assign mag_a    = in_neg_a ? (~SrcA + 1'b1) : SrcA;
  assign mag_b    = in_neg_b ? (~SrcB + 1'b1) : SrcB;

  // Multiply: low half of acc holds the multiplier, consumed LSB first
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic              unused_diff_bit;
  assign div_sh          = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff        = {1'b0, div_sh} - {2'b00, b_q};
  assign div_ge          = ~div_diff[XLEN+1];
  assign div_next        = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                            acc_q[XLEN-2:0], div_ge};
  assign unused_diff_bit = div_diff[XLEN];

  logic [2*XLEN-1:0] iter, prod;
  logic [XLEN-1:0]   quo, rem, fin;
  assign iter = op_q[2] ? div_next : mul_next;
  assign prod = (neg_a_q ^ neg_b_q) ? (~iter + 1'b1) : iter;
  // Divide-by-zero leaves an all-ones quotient; it must not be negated
  assign quo  = (neg_a_q ^ neg_b_q) && (b_q != '0) ? (~iter[XLEN-1:0] + 1'b1)
                                                   : iter[XLEN-1:0];
  assign rem  = neg_a_q ? (~iter[2*XLEN-1:XLEN] + 1'b1) : iter[2*XLEN-1:XLEN];

  always_comb begin
    fin = '0;
    case (op_q)
      3'b000:         fin = prod[XLEN-1:0];
      3'b100, 3'b101: fin = quo;
      3'b110, 3'b111: fin = rem;
      default:        fin = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        count_d = '0;
        acc_d   = {{XLEN{1'b0}}, mag_a};
        b_d     = mag_b;
        op_d    = funct3;
        neg_a_d = in_neg_a;
        neg_b_d = in_neg_b;
        rd_d    = rd_in;
      end
      CALC: begin
        acc_d   = iter;
        count_d = count_q + 1'b1;
        if (count_q == CW'(CYCLES-1)) begin
          state_d  = DONE;
          result_d = fin;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Random and directed stimulus for mul_div_unit against a plain-arithmetic model
// with a per-cycle timing/result scoreboard.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int ntests = 0;
  int nfail  = 0;

  mul_div_unit #(.XLEN(32), .CYCLES(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .SrcA(SrcA), .SrcB(SrcB), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * ub;
      3'd3:       p = {32'b0, a} * {32'b0, b};
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
    return (f == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: k = clock edges since the accepted start; >=33 means idle
  int          k = 100;
  logic [31:0] pend_res, exp_res = '0;
  logic [4:0]  pend_rd, exp_rd = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 100; exp_res = '0; exp_rd = '0;
    end else if (k >= 33) begin
      if (start) begin
        k = 0;
        pend_res = model(funct3, SrcA, SrcB);
        pend_rd  = rd_in;
      end
    end else begin
      k++;
      if (k == 32) begin exp_res = pend_res; exp_rd = pend_rd; end
    end
  end

  always @(negedge clk) begin
    chk("busy",   32'(busy),   32'(k <= 31));
    chk("done",   32'(done),   32'(k == 32));
    chk("result", result,      exp_res);
    chk("rd_out", 32'(rd_out), 32'(exp_rd));
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output int lat,
                       output int bcnt);
    @(negedge clk);
    start = 1'b1; funct3 = f; SrcA = a; SrcB = b; rd_in = rd;
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start  = (i == 10);
      funct3 = 3'($urandom);
      SrcA   = $urandom;
      SrcB   = $urandom;
      rd_in  = 5'($urandom);
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    res = result;
    chk("latency", 32'(lat), 32'd33);
    chk("busy_cycles", 32'(bcnt), 32'd32);
  endtask

  task automatic directed(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r;
    int lat, bc;
    chk({"model_", nm}, model(f, a, b), exp);
    do_op(f, a, b, 5'd5, r, lat, bc);
    chk({"dut_", nm}, r, exp);
    chk({"rd_", nm}, 32'(rd_out), 32'd5);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    int lat, bc;
    reset = 1'b1; start = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    directed("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    directed("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    directed("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    directed("divu",    3'd5, 32'd100,        32'd7,         32'd14);
    directed("remu",    3'd7, 32'd100,        32'd7,         32'd2);
    directed("div0",    3'd4, 32'h1234,       32'd0,         32'hFFFF_FFFF);
    directed("remu0",   3'd7, 32'h1234,       32'd0,         32'h1234);
    directed("divneg0", 3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);
    directed("remneg0", 3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
    directed("divovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    directed("removf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0);

    for (int n = 0; n < 50; n++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, 5'($urandom), r, lat, bc);
      chk("rand_result", r, model(f, a, b));
    end

    // Reset in the middle of a DIVU: outputs clear before the next edge
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", result,      32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd0, 32'd12345, 32'd678, 5'd17, r, lat, bc);
    chk("post_rst_mul", r, 32'd8369910);
    chk("post_rst_rd",  32'(rd_out), 32'd17);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
